// File: rtl/motor_pwm_ramp.sv
// Multi-channel H-bridge PWM generator with soft-start duty ramping and
// dead-period-protected direction reversal, all applied on period boundaries.
module motor_pwm_ramp #(
    parameter int CHANNELS  = 2,
    parameter int WIDTH     = 4,
    parameter int PRESCALE  = 2,
    parameter int RAMP_STEP = 1
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      EN,
    input  logic                      LOAD,
    input  logic [CHANNELS*WIDTH-1:0] DUTY_IN,
    input  logic [CHANNELS-1:0]       DIR_IN,
    output logic [CHANNELS-1:0]       OUT,
    output logic [CHANNELS-1:0]       DIR_OUT,
    output logic [CHANNELS-1:0]       BUSY,
    output logic                      PERIOD_END
);

    localparam int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int MAX_DUTY = (1 << WIDTH) - 1;
    // A step larger than full scale behaves exactly like a full-scale step.
    localparam int STEP_SAT = (RAMP_STEP > MAX_DUTY) ? MAX_DUTY : RAMP_STEP;

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] STEP    = STEP_SAT[WIDTH-1:0];

    logic [PRE_W-1:0]    r_presc;
    logic [WIDTH-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_duty     [CHANNELS];
    logic [WIDTH-1:0]    r_tgt_duty [CHANNELS];
    logic [CHANNELS-1:0] r_tgt_dir;
    logic [CHANNELS-1:0] r_dir;
    logic [CHANNELS-1:0] r_out;
    logic [CHANNELS-1:0] r_busy;
    logic                r_pe;

    logic                w_tick;
    logic                w_boundary;
    logic [PRE_W-1:0]    w_presc_nxt;
    logic [WIDTH-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0]    w_duty_nxt     [CHANNELS];
    logic [WIDTH-1:0]    w_tgt_duty_nxt [CHANNELS];
    logic [CHANNELS-1:0] w_tgt_dir_nxt;
    logic [CHANNELS-1:0] w_dir_nxt;
    logic [CHANNELS-1:0] w_out_nxt;
    logic [CHANNELS-1:0] w_busy_nxt;

    assign w_tick     = EN && (r_presc == PRE_MAX);
    assign w_boundary = w_tick && (r_cnt == '1);

    // Duty one boundary later: slew toward target when direction agrees,
    // otherwise drain toward zero so the bridge never reverses under load.
    function automatic logic [WIDTH-1:0] ramp_duty(
        input logic [WIDTH-1:0] d,
        input logic [WIDTH-1:0] tgt,
        input logic             same_dir
    );
        logic [WIDTH-1:0] res;
        res = d;
        if (same_dir) begin
            if (RAMP_STEP == 0)
                res = tgt;
            else if (tgt > d)
                res = ((tgt - d) <= STEP) ? tgt : d + STEP;
            else
                res = ((d - tgt) <= STEP) ? tgt : d - STEP;
        end else begin
            if (RAMP_STEP == 0 || d <= STEP)
                res = '0;
            else
                res = d - STEP;
        end
        return res;
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_presc_nxt   = r_presc;
        w_cnt_nxt     = r_cnt;
        w_tgt_dir_nxt = LOAD ? DIR_IN : r_tgt_dir;
        w_dir_nxt     = r_dir;
        w_out_nxt     = '0;
        w_busy_nxt    = '0;

        if (!EN) begin
            w_presc_nxt = '0;
            w_cnt_nxt   = '0;
        end else if (w_tick) begin
            w_presc_nxt = '0;
            w_cnt_nxt   = r_cnt + 1'b1;
        end else begin
            w_presc_nxt = r_presc + 1'b1;
        end

        for (int i = 0; i < CHANNELS; i++) begin
            w_tgt_duty_nxt[i] = LOAD ? DUTY_IN[i*WIDTH +: WIDTH] : r_tgt_duty[i];
            w_duty_nxt[i]     = r_duty[i];

            // The boundary consumes the targets held before any coincident LOAD.
            if (!EN) begin
                w_duty_nxt[i] = '0;
            end else if (w_boundary) begin
                w_duty_nxt[i] = ramp_duty(r_duty[i], r_tgt_duty[i],
                                          r_tgt_dir[i] == r_dir[i]);
                if (r_tgt_dir[i] != r_dir[i] && r_duty[i] == '0)
                    w_dir_nxt[i] = r_tgt_dir[i];
            end

            w_out_nxt[i]  = EN && (r_cnt < r_duty[i]);
            w_busy_nxt[i] = (w_duty_nxt[i] != w_tgt_duty_nxt[i]) ||
                            (w_dir_nxt[i]  != w_tgt_dir_nxt[i]);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_presc   <= '0;
            r_cnt     <= '0;
            r_tgt_dir <= '0;
            r_dir     <= '0;
            r_out     <= '0;
            r_busy    <= '0;
            r_pe      <= 1'b0;
            // NOTE: these per-channel arrays are flops, not RAM, so they take the async reset like any other state.
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty[i]     <= '0;
                r_tgt_duty[i] <= '0;
            end
        end else begin
            r_presc   <= w_presc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_tgt_dir <= w_tgt_dir_nxt;
            r_dir     <= w_dir_nxt;
            r_out     <= w_out_nxt;
            r_busy    <= w_busy_nxt;
            r_pe      <= w_boundary;
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty[i]     <= w_duty_nxt[i];
                r_tgt_duty[i] <= w_tgt_duty_nxt[i];
            end
        end
    end

    assign OUT        = r_out;
    assign DIR_OUT    = r_dir;
    assign BUSY       = r_busy;
    assign PERIOD_END = r_pe;

endmodule

// File: doc/motor_pwm_ramp.md
# motor_pwm_ramp

Multi-channel motor PWM generator with a parametrised resolution and clock prescaler. Each channel has a per-channel direction output and slew-rate-limited (soft-start) duty ramping. Duty and direction changes are double-buffered and only take effect at period boundaries. A direction reversal always ramps the channel to zero and inserts a dead period before `DIR_OUT` flips. The block sits between the motor-control register/command logic and the H-bridge driver pins.

## Interface
- `CHANNELS`, 2: number of independent PWM channels (≥1).
- `WIDTH`, 4: duty/counter resolution in bits; period = 2^WIDTH ticks.
- `PRESCALE`, 2: CLK cycles per tick (≥1); 1 = tick every clock.
- `RAMP_STEP`, 1: max duty change per period; 0 = no ramping (jump directly to target).
- `CLK` input 1: system clock, rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `EN` input 1: global enable; low forces outputs off and clears active duty.
- `LOAD` input 1: one-cycle strobe; captures `DUTY_IN`/`DIR_IN` into target registers.
- `DUTY_IN` input CHANNELS*WIDTH: target duties, channel i at bits [i*WIDTH +: WIDTH].
- `DIR_IN` input CHANNELS: target direction per channel.
- `OUT` output CHANNELS: registered PWM outputs.
- `DIR_OUT` output CHANNELS: registered applied direction per channel.
- `BUSY` output CHANNELS: high while channel i active duty ≠ target duty or `DIR_OUT[i]` ≠ target dir.
- `PERIOD_END` output 1: one-clock pulse on the period-wrap clock.

## Operation
- Reset (`RST_N`=0, asynchronous): prescaler, period counter, targets, active duties, `OUT`, `DIR_OUT`, `BUSY`, `PERIOD_END` all 0.
- Prescaler counts 0..PRESCALE-1 while `EN`=1. A tick is the clock where it equals PRESCALE-1. The period counter `cnt` (WIDTH bits) increments on each tick and wraps 2^WIDTH-1 → 0.
- Boundary = tick with `cnt`=2^WIDTH-1. On that clock `PERIOD_END`=1 (registered, visible the following cycle) and every channel updates its active duty `d` and `DIR_OUT`:
  - Target dir = `DIR_OUT`: `d` moves toward target by min(|target−d|, RAMP_STEP). With RAMP_STEP=0, `d` = target. No overshoot; arithmetic is unsigned and saturating.
  - Target dir ≠ `DIR_OUT` and `d`≠0: `d` decreases by RAMP_STEP, saturating at 0. With RAMP_STEP=0, `d`=0.
  - Target dir ≠ `DIR_OUT` and `d`=0: `DIR_OUT` flips and `d` stays 0. This guarantees at least one full zero-duty (dead) period on each side of the flip.
- `OUT[i]` next = `EN` & (`cnt` < `d[i]`). Duty 0 gives a constant low output. Duty 2^WIDTH−1 gives high for 2^WIDTH−1 of 2^WIDTH ticks.
- `LOAD`: targets are written on the `LOAD` clock. If `LOAD` coincides with a boundary, the boundary uses the previous targets and the new targets apply from the next boundary.
- `EN`=0: prescaler and `cnt` are held at 0, all `d` are cleared to 0, and `OUT`=0 from the next clock. Targets and `DIR_OUT` are retained. When `EN` rises, counting restarts from `cnt`=0 and the channels soft-start from 0.
- `BUSY` is registered and evaluated from the post-update state.

## Timing
- `OUT` latency: one clock after the `cnt`/`d` state it reflects.
- Period = PRESCALE·2^WIDTH clocks (defaults: 32 clocks, 16 ticks).
- New target seen at the first boundary after `LOAD`. Full ramp from 0 to D takes ceil(D/RAMP_STEP) periods.
- Reversal from duty D to target D′ with RAMP_STEP=s:
  - ceil(D/s) boundaries to reach 0;
  - one boundary to flip `DIR_OUT`;
  - ceil(D′/s) boundaries to reach D′.
- Reset is honoured mid-period at any cycle. No output glitch occurs on release: the first `OUT` high is possible only after `d`>0.

## Test plan
- Reset: run at duty 8, then pulse `RST_N` low mid-period → `OUT`, `DIR_OUT`, `BUSY`, `PERIOD_END` go 0 immediately, and stay 0 for the first boundary after release.
- RAMP_STEP=0, `EN`=1, `LOAD` ch0 duty 8 dir 0 → from the first boundary, ch0 `OUT` is high 16 clocks then low 16 clocks per 32-clock period, and `PERIOD_END` pulses every 32 clocks.
- RAMP_STEP=1, `LOAD` ch0 target 4 → active duty 1, 2, 3, 4 at successive periods, with `BUSY[0]` falling at the 4th boundary. RAMP_STEP=3 with the same target → 3, then 4 (no overshoot).
- Reversal, RAMP_STEP=1: ch0 at duty 3 dir 0, `LOAD` dir 1 duty 2 → duties 2, 1, 0, then 0 with `DIR_OUT` flipping to 1, then 1, 2. `OUT` stays low for two full periods around the flip.
- Extremes and channel independence: ch0 duty 0 and ch1 duty 15 → ch0 never high; ch1 high for 30 of 32 clocks. `LOAD` on a boundary clock applies only at the next boundary.
- `EN` dropped mid-period at duty 8 → `OUT` is 0 on the next clock and `cnt` is 0. Re-assert with RAMP_STEP=2 → duty 2, 4, 6, 8 from restart.
